tlc_phase_scheduler: RTL

Phase scheduler for the traffic-light controller. It arbitrates green time among four approaches (N, E, S, W) from vehicle-request inputs and sequences each phase through GREEN, YELLOW and ALL-RED clearance. It drives the 8-bit `light` bus that the intersection lamp drivers consume. All timing is counted in `tick` pulses, so one instance serves any timebase.

---
 rtl/tlc_phase_scheduler.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/tlc_phase_scheduler.sv
// Four-approach traffic-light phase scheduler: round-robin green arbitration with
// yellow and all-red clearance, timed in tick pulses. Optional pedestrian walk phase: TLC_PED_EN.
module tlc_phase_scheduler #(
    parameter int TW        = 8,
    parameter int MIN_GREEN = 5,
    parameter int MAX_GREEN = 20,
    parameter int YELLOW_T  = 3,
    parameter int ALLRED_T  = 2,
    parameter int WALK_T    = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic [3:0] req,
`ifdef TLC_PED_EN
    input  logic       ped_req,
    output logic       walk,
`endif
    output logic [7:0] light,
    output logic [3:0] grant,
    output logic [1:0] phase
);

    // State encoding doubles as the phase output code.
    typedef enum logic [1:0] {
        ST_ALLRED = 2'd0,
        ST_GREEN  = 2'd1,
`ifdef TLC_PED_EN
        ST_YELLOW = 2'd2,
        ST_WALK   = 2'd3
`else
        ST_YELLOW = 2'd2
`endif
    } state_t;

    if (MIN_GREEN < 1 || MAX_GREEN < MIN_GREEN || MAX_GREEN >= (1 << TW) ||
        YELLOW_T < 1 || ALLRED_T < 1 || WALK_T < 1) begin : g_bad_params
        $error("tlc_phase_scheduler: illegal timing parameters");
    end

    // Timer value on the tick that completes N ticks in the current state.
    localparam logic [TW-1:0] MIN_LAST    = TW'(MIN_GREEN - 1);
    localparam logic [TW-1:0] MAX_LAST    = TW'(MAX_GREEN - 1);
    localparam logic [TW-1:0] YELLOW_LAST = TW'(YELLOW_T - 1);
    localparam logic [TW-1:0] ALLRED_LAST = TW'(ALLRED_T - 1);
`ifdef TLC_PED_EN
    localparam logic [TW-1:0] WALK_LAST   = TW'(WALK_T - 1);
`endif

    state_t        state_q, state_d;
    logic [1:0]    idx_q, idx_d;
    logic [1:0]    rr_q, rr_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [7:0]    light_q, light_d;
    logic [3:0]    grant_q, grant_d;
    logic [1:0]    phase_q, phase_d;
`ifdef TLC_PED_EN
    logic          ped_q, ped_d;
    logic          walk_q, walk_d;
`endif

    logic [7:0] req_dbl;
    logic [3:0] req_rot;
    logic [1:0] pick_off;
    logic       others_waiting;
    logic       min_done;
    logic       max_done;
    logic       green_yield;

    // Rotate requests so bit 0 is the rr pointer's approach; first set bit wins.
    assign req_dbl = {req, req};
    assign req_rot = req_dbl[rr_q +: 4];

    always_comb begin
        pick_off = 2'd0;
        if (req_rot[0])      pick_off = 2'd0;
        else if (req_rot[1]) pick_off = 2'd1;
        else if (req_rot[2]) pick_off = 2'd2;
        else if (req_rot[3]) pick_off = 2'd3;
    end

    assign others_waiting = |(req & ~(4'b0001 << idx_q));
    assign min_done       = (timer_q >= MIN_LAST);
    assign max_done       = (timer_q >= MAX_LAST);

`ifdef TLC_PED_EN
    assign green_yield = min_done && (ped_q || (others_waiting && (!req[idx_q] || max_done)));
`else
    assign green_yield = min_done && others_waiting && (!req[idx_q] || max_done);
`endif

    always_comb begin
        // NOTE: every _d takes its _q value first, so no path through this block infers a latch.
        state_d = state_q;
        idx_d   = idx_q;
        rr_d    = rr_q;
        case (state_q)
            ST_ALLRED: begin
                if (tick && timer_q >= ALLRED_LAST) begin
`ifdef TLC_PED_EN
                    if (ped_q) begin
                        state_d = ST_WALK;
                    end else
`endif
                    if (|req) begin
                        state_d = ST_GREEN;
                        idx_d   = rr_q + pick_off;
                    end
                end
            end
            ST_GREEN: begin
                if (tick && green_yield) state_d = ST_YELLOW;
            end
            ST_YELLOW: begin
                if (tick && timer_q >= YELLOW_LAST) begin
                    state_d = ST_ALLRED;
                    rr_d    = idx_q + 2'd1;
                end
            end
`ifdef TLC_PED_EN
            ST_WALK: begin
                if (tick && timer_q >= WALK_LAST) state_d = ST_ALLRED;
            end
`endif
            default: state_d = ST_ALLRED;
        endcase

        timer_d = timer_q;
        if (state_d != state_q) timer_d = '0;
        else if (tick && timer_q != '1) timer_d = timer_q + 1'b1;

`ifdef TLC_PED_EN
        ped_d = ped_q;
        if (state_d == ST_WALK && state_q != ST_WALK) ped_d = 1'b0;
        else if (ped_req && state_q != ST_WALK)       ped_d = 1'b1;
        walk_d = (state_d == ST_WALK);
`endif

        // NOTE: outputs decode the next state so the registered lamps switch on the same edge as state_q.
        light_d = 8'h00;
        grant_d = 4'b0000;
        phase_d = state_d;
        if (state_d == ST_GREEN || state_d == ST_YELLOW) grant_d = 4'b0001 << idx_d;
        if (state_d == ST_GREEN)  light_d[{idx_d, 1'b0} +: 2] = 2'b01;
        if (state_d == ST_YELLOW) light_d[{idx_d, 1'b0} +: 2] = 2'b10;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_ALLRED;
            idx_q   <= 2'd0;
            rr_q    <= 2'd0;
            timer_q <= '0;
            light_q <= 8'h00;
            grant_q <= 4'b0000;
            phase_q <= 2'd0;
`ifdef TLC_PED_EN
            ped_q   <= 1'b0;
            walk_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            rr_q    <= rr_d;
            timer_q <= timer_d;
            light_q <= light_d;
            grant_q <= grant_d;
            phase_q <= phase_d;
`ifdef TLC_PED_EN
            ped_q   <= ped_d;
            walk_q  <= walk_d;
`endif
        end
    end

    assign light = light_q;
    assign grant = grant_q;
    assign phase = phase_q;
`ifdef TLC_PED_EN
    assign walk  = walk_q;
`endif

endmodule
